// File: rtl/unidade_controle_if.sv
// ============================================================================
// unidade_controle_if : start/instruction handshake and datapath control word
// Rev 1.0
// ============================================================================
`default_nettype none

interface unidade_controle_if;
    logic       inicia;
    logic [8:0] instrucao;
    logic       escreve_R1, escreve_R2, escreve_R3;
    logic       escreve_R4, escreve_R5, escreve_R6;
    logic       escreve_RDM, escreve_REM;
    logic [1:0] seleciona_mux1, seleciona_mux2;
    logic       seleciona_mux3, seleciona_mux4, seleciona_mux5;
    logic       RD, OE, CS;
    logic [2:0] codigo;
    logic       ocupado, concluido, parado, erro_reg;

    modport master (
        output inicia, instrucao,
        input  escreve_R1, escreve_R2, escreve_R3, escreve_R4, escreve_R5, escreve_R6,
        input  escreve_RDM, escreve_REM,
        input  seleciona_mux1, seleciona_mux2, seleciona_mux3, seleciona_mux4, seleciona_mux5,
        input  RD, OE, CS, codigo, ocupado, concluido, parado, erro_reg
    );

    modport slave (
        input  inicia, instrucao,
        output escreve_R1, escreve_R2, escreve_R3, escreve_R4, escreve_R5, escreve_R6,
        output escreve_RDM, escreve_REM,
        output seleciona_mux1, seleciona_mux2, seleciona_mux3, seleciona_mux4, seleciona_mux5,
        output RD, OE, CS, codigo, ocupado, concluido, parado, erro_reg
    );
endinterface

`default_nettype wire

// File: rtl/unidade_controle.sv
// ============================================================================
// unidade_controle : multicycle Moore control FSM for the simple CPU datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module unidade_controle #(
    parameter int LAT_MEM = 2,
    parameter int CNT_W   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    unidade_controle_if.slave    bus
);

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        DECODIFICA  = 4'd1,
        EXECUTA     = 4'd2,
        ENDERECO    = 4'd3,
        LEITURA     = 4'd4,
        ESCREVE_REG = 4'd5,
        DADO        = 4'd6,
        GRAVA       = 4'd7,
        FIM         = 4'd8,
        PARADO      = 4'd9
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_MEM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t           state, next_state;
    logic [8:0]       instr;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op, rd, rs;
    logic             cnt_done, rd_ok;
    logic [2:0]       sel_rd, sel_rs;
    logic [5:0]       wr_onehot;

    // {bank, low}: R1..R4 -> bank 0, R5..R6 -> bank 1; invalid indices fall back to R1
    function automatic logic [2:0] map_sel(input logic [2:0] r);
        logic [2:0] m;
        m = 3'b000;
        if (r >= 3'd1 && r <= 3'd4)
            m = {1'b0, 2'(r - 3'd1)};
        else if (r == 3'd5 || r == 3'd6)
            m = {1'b1, 2'(r - 3'd5)};
        return m;
    endfunction

    assign op        = instr[8:6];
    assign rd        = instr[5:3];
    assign rs        = instr[2:0];
    assign rd_ok     = (rd != 3'd0) && (rd != 3'd7);
    assign sel_rd    = map_sel(rd);
    assign sel_rs    = map_sel(rs);
    assign wr_onehot = rd_ok ? (6'b000001 << (rd - 3'd1)) : 6'b000000;
    assign cnt_done  = (cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= OCIOSO;
            instr <= 9'd0;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state == OCIOSO && bus.inicia)
                instr <= bus.instrucao;
            if ((next_state == LEITURA && state != LEITURA) ||
                (next_state == GRAVA   && state != GRAVA))
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            OCIOSO:      if (bus.inicia) next_state = DECODIFICA;
            DECODIFICA: begin
                case (op)
                    3'd4, 3'd5: next_state = ENDERECO;
                    3'd7:       next_state = PARADO;
                    default:    next_state = EXECUTA;
                endcase
            end
            EXECUTA:     next_state = FIM;
            ENDERECO:    next_state = (op == 3'd4) ? LEITURA : DADO;
            LEITURA:     if (cnt_done) next_state = ESCREVE_REG;
            ESCREVE_REG: next_state = FIM;
            DADO:        next_state = GRAVA;
            GRAVA:       if (cnt_done) next_state = FIM;
            FIM:         next_state = OCIOSO;
            PARADO:      next_state = PARADO;
            default:     next_state = OCIOSO;
        endcase
    end

    logic [5:0] wr;
    logic       en_rdm, en_rem, mux3, mux4, mux5, rd_n, oe_n, cs_n;
    logic [1:0] mux1, mux2;
    logic [2:0] alu;
    logic       busy, done, halted, err;

    always_comb begin
        wr     = 6'b000000;
        en_rdm = 1'b0;
        en_rem = 1'b0;
        mux1   = 2'b00;
        mux2   = 2'b00;
        mux3   = 1'b0;
        mux4   = 1'b0;
        mux5   = 1'b0;
        rd_n   = 1'b1;
        oe_n   = 1'b1;
        cs_n   = 1'b1;
        alu    = 3'b000;
        busy   = (state != OCIOSO) && (state != PARADO);
        done   = 1'b0;
        halted = 1'b0;
        err    = 1'b0;
        case (state)
            EXECUTA: begin
                {mux3, mux1} = sel_rd;
                {mux4, mux2} = sel_rs;
                alu          = op;
                wr           = wr_onehot;
                err          = ~rd_ok;
            end
            ENDERECO: begin
                {mux4, mux2} = sel_rs;
                alu          = 3'b110;
                en_rem       = 1'b1;
            end
            LEITURA: begin
                cs_n   = 1'b0;
                oe_n   = 1'b0;
                en_rdm = cnt_done;
            end
            ESCREVE_REG: begin
                mux5 = 1'b1;
                wr   = wr_onehot;
                err  = ~rd_ok;
            end
            DADO: begin
                {mux4, mux2} = sel_rd;
                alu          = 3'b110;
                en_rdm       = 1'b1;
            end
            GRAVA: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
            end
            FIM:     done   = 1'b1;
            PARADO:  halted = 1'b1;
            default: ;
        endcase
    end

    assign {bus.escreve_R6, bus.escreve_R5, bus.escreve_R4,
            bus.escreve_R3, bus.escreve_R2, bus.escreve_R1} = wr;
    assign bus.escreve_RDM    = en_rdm;
    assign bus.escreve_REM    = en_rem;
    assign bus.seleciona_mux1 = mux1;
    assign bus.seleciona_mux2 = mux2;
    assign bus.seleciona_mux3 = mux3;
    assign bus.seleciona_mux4 = mux4;
    assign bus.seleciona_mux5 = mux5;
    assign bus.RD             = rd_n;
    assign bus.OE             = oe_n;
    assign bus.CS             = cs_n;
    assign bus.codigo         = alu;
    assign bus.ocupado        = busy;
    assign bus.concluido      = done;
    assign bus.parado         = halted;
    assign bus.erro_reg       = err;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle.sv
// ============================================================================
// tb_unidade_controle : scoreboard bench comparing the full control word per cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_unidade_controle;

    localparam int LAT = 2;

    typedef logic [24:0] word_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    unidade_controle_if bus ();

    unidade_controle #(.LAT_MEM(LAT), .CNT_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    word_t exp_q[$];
    word_t idle_exp;
    word_t act;
    word_t e_mon;
    int    vectors     = 0;
    int    miscompares = 0;
    bit    mon_en      = 1'b0;

    // a = {mux3, mux1}, b = {mux4, mux2}
    function automatic word_t mk(input logic [5:0] wr, input logic rdm, input logic rem,
                                 input logic [2:0] a, input logic [2:0] b, input logic m5,
                                 input logic rdv, input logic oe, input logic cs,
                                 input logic [2:0] cod, input logic ocu, input logic con,
                                 input logic par, input logic err);
        return {wr, rdm, rem, a[1:0], b[1:0], a[2], b[2], m5, rdv, oe, cs, cod, ocu, con, par, err};
    endfunction

    function automatic logic [2:0] sel(input logic [2:0] r);
        case (r)
            3'd1:    return 3'b000;
            3'd2:    return 3'b001;
            3'd3:    return 3'b010;
            3'd4:    return 3'b011;
            3'd5:    return 3'b100;
            3'd6:    return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [5:0] oh(input logic [2:0] r);
        case (r)
            3'd1:    return 6'b000001;
            3'd2:    return 6'b000010;
            3'd3:    return 6'b000100;
            3'd4:    return 6'b001000;
            3'd5:    return 6'b010000;
            3'd6:    return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    assign act = {bus.escreve_R6, bus.escreve_R5, bus.escreve_R4, bus.escreve_R3,
                  bus.escreve_R2, bus.escreve_R1, bus.escreve_RDM, bus.escreve_REM,
                  bus.seleciona_mux1, bus.seleciona_mux2, bus.seleciona_mux3,
                  bus.seleciona_mux4, bus.seleciona_mux5, bus.RD, bus.OE, bus.CS,
                  bus.codigo, bus.ocupado, bus.concluido, bus.parado, bus.erro_reg};

    // Monitor: one expected word per cycle; an empty queue means the quiescent word.
    always @(negedge clock) begin
        if (mon_en) begin
            if (exp_q.size() > 0) e_mon = exp_q.pop_front();
            else                  e_mon = idle_exp;
            vectors++;
            if (act !== e_mon) begin
                miscompares++;
                $display("FAIL control_word t=%0t actual=%h expected=%h", $time, act, e_mon);
            end
        end
    end

    word_t w_idle, w_dec, w_fim, w_halt;

    task automatic push_expected(input logic [8:0] ins);
        logic [2:0] op, rd, rs;
        logic       bad;
        op  = ins[8:6];
        rd  = ins[5:3];
        rs  = ins[2:0];
        bad = (rd == 3'd0) || (rd == 3'd7);
        exp_q.push_back(w_dec);
        case (op)
            3'd4: begin
                exp_q.push_back(mk(6'd0, 0, 1, 3'b000, sel(rs), 0, 1, 1, 1, 3'b110, 1, 0, 0, 0));
                for (int i = 0; i < LAT; i++)
                    exp_q.push_back(mk(6'd0, (i == LAT - 1), 0, 3'b000, 3'b000, 0, 1, 0, 0, 3'b000, 1, 0, 0, 0));
                exp_q.push_back(mk(oh(rd), 0, 0, 3'b000, 3'b000, 1, 1, 1, 1, 3'b000, 1, 0, 0, bad));
                exp_q.push_back(w_fim);
            end
            3'd5: begin
                exp_q.push_back(mk(6'd0, 0, 1, 3'b000, sel(rs), 0, 1, 1, 1, 3'b110, 1, 0, 0, 0));
                exp_q.push_back(mk(6'd0, 1, 0, 3'b000, sel(rd), 0, 1, 1, 1, 3'b110, 1, 0, 0, 0));
                for (int i = 0; i < LAT; i++)
                    exp_q.push_back(mk(6'd0, 0, 0, 3'b000, 3'b000, 0, 0, 1, 0, 3'b000, 1, 0, 0, 0));
                exp_q.push_back(w_fim);
            end
            3'd7: idle_exp = w_halt;
            default: begin
                exp_q.push_back(mk(oh(rd), 0, 0, sel(rd), sel(rs), 0, 1, 1, 1, op, 1, 0, 0, bad));
                exp_q.push_back(w_fim);
            end
        endcase
    endtask

    // Accept on the second edge; the instruction bus is scrambled afterwards to prove latching.
    task automatic issue(input logic [8:0] ins, input int keep, input bit extra);
        @(posedge clock); #1;
        bus.inicia    = 1'b1;
        bus.instrucao = ins;
        @(posedge clock); #1;
        bus.inicia    = 1'b0;
        bus.instrucao = ~ins;
        push_expected(ins);
        if (keep > 0)
            while (exp_q.size() > keep) void'(exp_q.pop_back());
        if (extra) begin
            @(posedge clock); #1;
            bus.inicia = 1'b1;
            @(posedge clock); #1;
            bus.inicia = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clock);
    endtask

    initial begin
        w_idle   = mk(6'd0, 0, 0, 3'b000, 3'b000, 0, 1, 1, 1, 3'b000, 0, 0, 0, 0);
        w_dec    = mk(6'd0, 0, 0, 3'b000, 3'b000, 0, 1, 1, 1, 3'b000, 1, 0, 0, 0);
        w_fim    = mk(6'd0, 0, 0, 3'b000, 3'b000, 0, 1, 1, 1, 3'b000, 1, 1, 0, 0);
        w_halt   = mk(6'd0, 0, 0, 3'b000, 3'b000, 0, 1, 1, 1, 3'b000, 0, 0, 1, 0);
        idle_exp = w_idle;
        bus.inicia    = 1'b0;
        bus.instrucao = 9'd0;
        reset         = 1'b1;

        @(posedge clock); #1;
        mon_en = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        issue(9'b000_010_101, 0, 1'b1); drain();   // ALU op0, R2,R5; extra inicia while busy
        issue(9'b011_101_110, 0, 1'b0); drain();   // ALU op3, R5,R6
        issue(9'b110_001_100, 0, 1'b0); drain();   // MOV R1 <= R4
        issue(9'b110_000_011, 0, 1'b0); drain();   // MOV invalid rd
        issue(9'b100_110_001, 0, 1'b0); drain();   // LOAD R6 <= M[R1]
        issue(9'b100_000_111, 0, 1'b0); drain();   // LOAD invalid rd, invalid rs
        issue(9'b101_011_100, 0, 1'b0); drain();   // STORE M[R4] <= R3
        issue(9'b101_111_010, 0, 1'b0); drain();   // STORE invalid rd stores R1

        // STORE interrupted by reset during the first GRAVA cycle
        issue(9'b101_011_100, 4, 1'b0);
        repeat (3) @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        drain();
        repeat (3) @(posedge clock);

        // HALT, a later ignored start, then reset clears it
        issue(9'b111_000_000, 0, 1'b0); drain();
        @(posedge clock); #1;
        bus.inicia    = 1'b1;
        bus.instrucao = 9'b000_001_001;
        @(posedge clock); #1;
        bus.inicia = 1'b0;
        repeat (4) @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset    = 1'b0;
        idle_exp = w_idle;
        repeat (3) @(posedge clock);
        issue(9'b001_100_010, 0, 1'b0); drain();   // still functional after halt/reset

        @(posedge clock); #1;
        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
